// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags for the rename path.
// Commit frees tags at the tail; misprediction reverts push tags back at the head.
module phys_reg_free_list #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
  parameter int PT            = $clog2(NUM_PHYS_REGS),
  parameter int PW            = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          nRST,
  output logic          DUT_error,
  input  logic          dequeue_valid,
  output logic          dequeue_ready,
  output logic [PT-1:0] dequeue_phys_reg_tag,
  input  logic          enqueue_valid,
  input  logic [PT-1:0] enqueue_phys_reg_tag,
  output logic          enqueue_ready,
  input  logic          revert_valid,
  input  logic [PT-1:0] revert_phys_reg_tag,
  output logic [PW-1:0] free_count
);

  localparam int IW = PW - 1;

  logic [PT-1:0] entries [DEPTH];
  logic [PW-1:0] head_ptr, tail_ptr;
  logic [PW-1:0] next_head_ptr, next_tail_ptr;
  logic [PW-1:0] head_m1;
  logic          next_DUT_error;
  logic          empty, full;
  logic          rev_ok, deq_ok, enq_ok;
  logic          enq_room;

  assign empty      = (head_ptr == tail_ptr);
  assign full       = (head_ptr[IW-1:0] == tail_ptr[IW-1:0]) &&
                      (head_ptr[PW-1] != tail_ptr[PW-1]);
  assign free_count = tail_ptr - head_ptr;
  assign head_m1    = head_ptr - PW'(1);

  assign dequeue_ready        = ~empty;
  assign enqueue_ready        = ~full;
  assign dequeue_phys_reg_tag = entries[head_ptr[IW-1:0]];

  // An accepted revert consumes one slot, so an enqueue in the same cycle
  // needs room for two when the FIFO is one short of full.
  always_comb begin
    rev_ok         = 1'b0;
    deq_ok         = 1'b0;
    enq_ok         = 1'b0;
    enq_room       = 1'b0;
    next_DUT_error = 1'b0;
    next_head_ptr  = head_ptr;
    next_tail_ptr  = tail_ptr;

    if (revert_valid) begin
      if (!full && (revert_phys_reg_tag != '0)) begin
        rev_ok = 1'b1;
      end else begin
        next_DUT_error = 1'b1;
      end
    end

    if (dequeue_valid) begin
      if (revert_valid || empty) begin
        next_DUT_error = 1'b1;
      end else begin
        deq_ok = 1'b1;
      end
    end

    enq_room = !full && !(rev_ok && (free_count == PW'(DEPTH - 1)));
    if (enqueue_valid) begin
      if (enq_room && (enqueue_phys_reg_tag != '0)) begin
        enq_ok = 1'b1;
      end else begin
        next_DUT_error = 1'b1;
      end
    end

    if (rev_ok) begin
      next_head_ptr = head_m1;
    end else if (deq_ok) begin
      next_head_ptr = head_ptr + PW'(1);
    end

    if (enq_ok) begin
      next_tail_ptr = tail_ptr + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr  <= '0;
      tail_ptr  <= PW'(DEPTH);
      DUT_error <= 1'b0;
    end else begin
      head_ptr  <= next_head_ptr;
      tail_ptr  <= next_tail_ptr;
      DUT_error <= next_DUT_error;
    end
  end

  // Reset contents are the tags not claimed by the architectural mapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PT'(NUM_ARCH_REGS + i);
      end
    end else begin
      if (rev_ok) begin
        entries[head_m1[IW-1:0]] <= revert_phys_reg_tag;
      end
      if (enq_ok) begin
        entries[tail_ptr[IW-1:0]] <= enqueue_phys_reg_tag;
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and random checks of phys_reg_free_list against a queue-based model.
module tb_phys_reg_free_list;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       DUT_error;
  logic       dequeue_valid = 1'b0;
  logic       dequeue_ready;
  logic [5:0] dequeue_phys_reg_tag;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_phys_reg_tag = '0;
  logic       enqueue_ready;
  logic       revert_valid = 1'b0;
  logic [5:0] revert_phys_reg_tag = '0;
  logic [5:0] free_count;

  int n_checks = 0;
  int n_fails  = 0;
  int q[$];

  phys_reg_free_list dut (
    .CLK(CLK), .nRST(nRST), .DUT_error(DUT_error),
    .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready),
    .dequeue_phys_reg_tag(dequeue_phys_reg_tag),
    .enqueue_valid(enqueue_valid), .enqueue_phys_reg_tag(enqueue_phys_reg_tag),
    .enqueue_ready(enqueue_ready),
    .revert_valid(revert_valid), .revert_phys_reg_tag(revert_phys_reg_tag),
    .free_count(free_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
  endtask

  task automatic check_outputs(input string where);
    check({where, " free_count"}, 32'(free_count), q.size());
    check({where, " dequeue_ready"}, 32'(dequeue_ready), (q.size() > 0) ? 1 : 0);
    check({where, " enqueue_ready"}, 32'(enqueue_ready), (q.size() < 32) ? 1 : 0);
    if (q.size() > 0) check({where, " head_tag"}, 32'(dequeue_phys_reg_tag), q[0]);
  endtask

  // Drive one cycle of requests, check pre-edge outputs and the post-edge error flag.
  task automatic step(input bit ev, input int et, input bit dv, input bit rv, input int rt);
    bit rev_ok, deq_ok, enq_ok, err;
    int cnt;
    @(negedge CLK);
    enqueue_valid = ev; enqueue_phys_reg_tag = 6'(et);
    dequeue_valid = dv;
    revert_valid = rv; revert_phys_reg_tag = 6'(rt);
    #1;
    check_outputs("pre");
    cnt    = q.size();
    rev_ok = rv && (cnt < 32) && (rt != 0);
    deq_ok = dv && !rv && (cnt > 0);
    enq_ok = ev && (et != 0) && ((cnt + (rev_ok ? 1 : 0)) < 32);
    err    = (dv && (rv || cnt == 0)) || (ev && !enq_ok) || (rv && !rev_ok);
    @(posedge CLK);
    #1;
    if (rev_ok) q.push_front(rt);
    if (deq_ok) void'(q.pop_front());
    if (enq_ok) q.push_back(et);
    check("DUT_error", 32'(DUT_error), err ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    enqueue_valid = 0; dequeue_valid = 0; revert_valid = 0;
    #1;
    model_reset();
    check_outputs("reset");
    check("reset DUT_error", 32'(DUT_error), 0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Drain all 32 reset tags, then underflow.
    for (int i = 0; i < 32; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("empty free_count", 32'(free_count), 0);

    // Enqueue into empty with a simultaneous (illegal) dequeue; no bypass.
    step(1, 5, 1, 0, 0);
    step(1, 7, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Three dequeues then revert 34.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 34);
    check("revert head", 32'(dequeue_phys_reg_tag), 34);
    check("revert count", 32'(free_count), 30);

    // Down to 10 entries, then revert plus enqueue together.
    while (q.size() > 10) step(0, 0, 1, 0, 0);
    step(1, 40, 0, 1, 34);
    check("rev+enq count", 32'(free_count), 12);
    check("rev+enq head", 32'(dequeue_phys_reg_tag), 34);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);

    // Enqueue while full, then tag 0 while not full, then revert+dequeue.
    do_reset();
    step(1, 9, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 33);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 12);

    // One short of full: revert accepted, enqueue rejected.
    do_reset();
    step(0, 0, 1, 0, 0);
    step(1, 21, 0, 1, 32);
    check("rev+enq@31 count", 32'(free_count), 32);

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 600; n++) begin
      bit rv, dv, ev;
      int et, rt;
      if (n == 300) do_reset();
      rv = ($urandom_range(0, 99) < 12);
      dv = ($urandom_range(0, 99) < 50);
      ev = ($urandom_range(0, 99) < 45);
      et = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 63);
      rt = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 63);
      step(ev, et, dv, rv, rt);
    end
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
